// File: rtl/mshr_scoreboard.sv
// rtl/mshr_scoreboard.sv - tagged load-miss register scoreboard with dependency, waw and drain stalls
module mshr_scoreboard #(
    parameter int DEPTH = 4,
    parameter int REG_W = 5,
    parameter int NSRC  = 2,
    parameter int TAG_W = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  alloc_valid,
    input  logic [REG_W-1:0]      alloc_rd,
    output logic                  alloc_ready,
    output logic [TAG_W-1:0]      alloc_tag,
    input  logic                  fill_valid,
    input  logic [TAG_W-1:0]      fill_tag,
    output logic [REG_W-1:0]      fill_rd,
    output logic                  fill_err,
    input  logic [NSRC-1:0]       src_valid,
    input  logic [NSRC*REG_W-1:0] src_rd,
    output logic                  dep_stall,
    input  logic                  drain_req,
    output logic                  drain_stall,
    output logic                  full,
    output logic                  empty,
    output logic [TAG_W:0]        count
);

    logic [DEPTH-1:0] slot_valid;
    logic [REG_W-1:0] slot_rd [DEPTH];
    logic             fill_hit;
    logic             waw;
    logic             alloc_fire;

    assign full        = (count == (TAG_W+1)'(DEPTH));
    assign empty       = (count == '0);
    assign alloc_ready = !full && !waw;
    assign alloc_fire  = alloc_valid && alloc_ready;
    assign drain_stall = drain_req && !empty;

    // Tag decode by comparison keeps out-of-range tags (non power-of-two DEPTH) harmless.
    always_comb begin
        fill_hit = 1'b0;
        fill_rd  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (fill_tag == TAG_W'(i)) begin
                fill_hit = fill_valid && slot_valid[i];
                fill_rd  = slot_rd[i];
            end
        end
    end

    // Lowest free slot wins; slots being filled this cycle still count as occupied.
    always_comb begin
        alloc_tag = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (!slot_valid[i]) begin
                alloc_tag = TAG_W'(i);
            end
        end
    end

    always_comb begin
        waw       = 1'b0;
        dep_stall = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (slot_valid[i] && alloc_rd != '0 && slot_rd[i] == alloc_rd) begin
                waw = 1'b1;
            end
            for (int s = 0; s < NSRC; s++) begin
                if (slot_valid[i] && src_valid[s] && src_rd[s*REG_W +: REG_W] != '0
                    && src_rd[s*REG_W +: REG_W] == slot_rd[i]) begin
                    dep_stall = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_valid <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                slot_rd[i] <= '0;
            end
            count    <= '0;
            fill_err <= 1'b0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (alloc_fire && alloc_tag == TAG_W'(i)) begin
                    slot_valid[i] <= 1'b1;
                    slot_rd[i]    <= alloc_rd;
                end else if (fill_hit && fill_tag == TAG_W'(i)) begin
                    slot_valid[i] <= 1'b0;
                end
            end
            case ({alloc_fire, fill_hit})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            fill_err <= fill_valid && !fill_hit;
        end
    end

endmodule

// File: tb/tb_mshr_scoreboard.sv
// tb/tb_mshr_scoreboard.sv - table-driven checks of mshr_scoreboard plus async reset sequence
module tb_mshr_scoreboard;

    localparam int DEPTH = 4;
    localparam int REG_W = 5;
    localparam int NSRC  = 2;
    localparam int TAG_W = 2;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic                  alloc_valid;
    logic [REG_W-1:0]      alloc_rd;
    logic                  alloc_ready;
    logic [TAG_W-1:0]      alloc_tag;
    logic                  fill_valid;
    logic [TAG_W-1:0]      fill_tag;
    logic [REG_W-1:0]      fill_rd;
    logic                  fill_err;
    logic [NSRC-1:0]       src_valid;
    logic [NSRC*REG_W-1:0] src_rd;
    logic                  dep_stall;
    logic                  drain_req;
    logic                  drain_stall;
    logic                  full;
    logic                  empty;
    logic [TAG_W:0]        count;

    int n_cmp = 0;
    int n_bad = 0;

    mshr_scoreboard #(.DEPTH(DEPTH), .REG_W(REG_W), .NSRC(NSRC)) dut (
        .clk(clk), .rst_n(rst_n),
        .alloc_valid(alloc_valid), .alloc_rd(alloc_rd), .alloc_ready(alloc_ready), .alloc_tag(alloc_tag),
        .fill_valid(fill_valid), .fill_tag(fill_tag), .fill_rd(fill_rd), .fill_err(fill_err),
        .src_valid(src_valid), .src_rd(src_rd), .dep_stall(dep_stall),
        .drain_req(drain_req), .drain_stall(drain_stall),
        .full(full), .empty(empty), .count(count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       av;
        logic [4:0] ard;
        logic       fv;
        logic [1:0] ftag;
        logic [1:0] sv;
        logic [9:0] srd;
        logic       dr;
        logic       e_ready;
        logic [1:0] e_tag;
        logic       chk_frd;
        logic [4:0] e_frd;
        logic       e_ferr;
        logic       e_dep;
        logic       e_drain;
        logic       e_full;
        logic       e_empty;
        logic [2:0] e_cnt;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic av, logic [4:0] ard, logic fv, logic [1:0] ftag,
                                logic [1:0] sv, logic [9:0] srd, logic dr,
                                logic e_ready, logic [1:0] e_tag, logic chk_frd, logic [4:0] e_frd,
                                logic e_ferr, logic e_dep, logic e_drain,
                                logic e_full, logic e_empty, logic [2:0] e_cnt);
        vec_t v;
        v = '{av, ard, fv, ftag, sv, srd, dr, e_ready, e_tag, chk_frd, e_frd,
              e_ferr, e_dep, e_drain, e_full, e_empty, e_cnt};
        return v;
    endfunction

    task automatic chk(input string name, input int idx, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s vec %0d: got %0d expected %0d", name, idx, act, exp);
        end
    endtask

    task automatic drive_idle();
        alloc_valid = 1'b0; alloc_rd = '0;
        fill_valid  = 1'b0; fill_tag = '0;
        src_valid   = '0;   src_rd   = '0;
        drain_req   = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        drive_idle();

        // av ard fv ftag sv srd dr | ready tag chkfrd frd ferr dep drain full empty cnt
        tbl.push_back(mk(0, 0,  0,0, 0,0,      0,  1,0, 0,0,  0,0,0, 0,1,0)); // 0 reset state
        tbl.push_back(mk(1, 3,  0,0, 0,0,      0,  1,0, 0,0,  0,0,0, 0,1,0)); // 1
        tbl.push_back(mk(1, 7,  0,0, 0,0,      0,  1,1, 0,0,  0,0,0, 0,0,1)); // 2
        tbl.push_back(mk(1, 9,  0,0, 0,0,      0,  1,2, 0,0,  0,0,0, 0,0,2)); // 3
        tbl.push_back(mk(1, 12, 0,0, 0,0,      0,  1,3, 0,0,  0,0,0, 0,0,3)); // 4
        tbl.push_back(mk(1, 20, 0,0, 0,0,      0,  0,0, 0,0,  0,0,0, 1,0,4)); // 5 full, refused
        tbl.push_back(mk(0, 0,  0,0, 0,0,      0,  0,0, 0,0,  0,0,0, 1,0,4)); // 6
        tbl.push_back(mk(0, 0,  1,2, 0,0,      0,  0,0, 1,9,  0,0,0, 1,0,4)); // 7 fill tag2
        tbl.push_back(mk(1, 5,  0,0, 0,0,      0,  1,2, 0,0,  0,0,0, 0,0,3)); // 8 reuse tag2
        tbl.push_back(mk(1, 15, 1,2, 0,0,      0,  0,0, 1,5,  0,0,0, 1,0,4)); // 9 full+fill: refused
        tbl.push_back(mk(1, 15, 0,0, 0,0,      0,  1,2, 0,0,  0,0,0, 0,0,3)); // 10 ready next cycle
        tbl.push_back(mk(0, 0,  1,3, 0,0,      0,  0,0, 1,12, 0,0,0, 1,0,4)); // 11
        tbl.push_back(mk(0, 0,  1,2, 0,0,      0,  1,0, 1,15, 0,0,0, 0,0,3)); // 12
        tbl.push_back(mk(0, 0,  1,1, 3,10'd224,0,  1,0, 1,7,  0,1,0, 0,0,2)); // 13 src {7,0}, fill rd7
        tbl.push_back(mk(0, 0,  0,0, 3,10'd224,0,  1,0, 0,0,  0,0,0, 0,0,1)); // 14 released
        tbl.push_back(mk(0, 0,  0,0, 3,10'd0,  0,  1,0, 0,0,  0,0,0, 0,0,1)); // 15 src 0
        tbl.push_back(mk(0, 0,  0,0, 2,10'd3,  0,  1,0, 0,0,  0,0,0, 0,0,1)); // 16 invalid operand
        tbl.push_back(mk(0, 0,  0,0, 1,10'd3,  0,  1,0, 0,0,  0,1,0, 0,0,1)); // 17 match rd3
        tbl.push_back(mk(1, 7,  0,0, 0,0,      0,  1,1, 0,0,  0,0,0, 0,0,1)); // 18
        tbl.push_back(mk(1, 7,  0,0, 0,0,      0,  0,0, 0,0,  0,0,0, 0,0,2)); // 19 waw
        tbl.push_back(mk(1, 0,  0,0, 0,0,      0,  1,2, 0,0,  0,0,0, 0,0,2)); // 20 rd0
        tbl.push_back(mk(1, 0,  0,0, 3,10'd0,  0,  1,3, 0,0,  0,0,0, 0,0,3)); // 21 rd0 again
        tbl.push_back(mk(0, 0,  0,0, 3,10'd0,  0,  0,0, 0,0,  0,0,0, 1,0,4)); // 22
        tbl.push_back(mk(0, 0,  1,3, 0,0,      1,  0,0, 1,0,  0,0,1, 1,0,4)); // 23 drain
        tbl.push_back(mk(0, 0,  1,2, 0,0,      1,  1,0, 1,0,  0,0,1, 0,0,3)); // 24
        tbl.push_back(mk(0, 0,  1,0, 0,0,      1,  1,0, 1,3,  0,0,1, 0,0,2)); // 25
        tbl.push_back(mk(0, 0,  1,1, 0,0,      1,  1,0, 1,7,  0,0,1, 0,0,1)); // 26 last fill
        tbl.push_back(mk(0, 0,  0,0, 0,0,      1,  1,0, 0,0,  0,0,0, 0,1,0)); // 27 drain released
        tbl.push_back(mk(0, 0,  1,1, 0,0,      0,  1,0, 0,0,  0,0,0, 0,1,0)); // 28 bad fill
        tbl.push_back(mk(0, 0,  0,0, 0,0,      0,  1,0, 0,0,  1,0,0, 0,1,0)); // 29 fill_err pulse
        tbl.push_back(mk(0, 0,  0,0, 0,0,      0,  1,0, 0,0,  0,0,0, 0,1,0)); // 30

        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        foreach (tbl[i]) begin
            @(negedge clk);
            alloc_valid = tbl[i].av;   alloc_rd = tbl[i].ard;
            fill_valid  = tbl[i].fv;   fill_tag = tbl[i].ftag;
            src_valid   = tbl[i].sv;   src_rd   = tbl[i].srd;
            drain_req   = tbl[i].dr;
            #1;
            chk("alloc_ready", i, int'(alloc_ready), int'(tbl[i].e_ready));
            if (tbl[i].av && tbl[i].e_ready) chk("alloc_tag", i, int'(alloc_tag), int'(tbl[i].e_tag));
            if (tbl[i].chk_frd) chk("fill_rd", i, int'(fill_rd), int'(tbl[i].e_frd));
            chk("fill_err", i, int'(fill_err), int'(tbl[i].e_ferr));
            chk("dep_stall", i, int'(dep_stall), int'(tbl[i].e_dep));
            chk("drain_stall", i, int'(drain_stall), int'(tbl[i].e_drain));
            chk("full", i, int'(full), int'(tbl[i].e_full));
            chk("empty", i, int'(empty), int'(tbl[i].e_empty));
            chk("count", i, int'(count), int'(tbl[i].e_cnt));
        end

        // Asynchronous reset with three live slots, then a late fill of a discarded tag.
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            drive_idle();
            alloc_valid = 1'b1; alloc_rd = 5'(4 + k);
        end
        @(negedge clk);
        drive_idle();
        #1;
        chk("pre_rst_count", 100, int'(count), 3);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_count", 101, int'(count), 0);
        chk("rst_empty", 101, int'(empty), 1);
        chk("rst_ready", 101, int'(alloc_ready), 1);
        @(negedge clk);
        rst_n = 1'b1;
        fill_valid = 1'b1; fill_tag = 2'd1;
        #1;
        chk("late_fill_err_now", 102, int'(fill_err), 0);
        @(negedge clk);
        drive_idle();
        #1;
        chk("late_fill_err", 103, int'(fill_err), 1);
        chk("late_fill_count", 103, int'(count), 0);
        @(negedge clk);
        #1;
        chk("late_fill_err_clr", 104, int'(fill_err), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
